shift_sequencer: RTL

- Iterative controller for the 8-bit shifter datapath.
- Selects one operand from two source buses, then shifts it one bit per clock for a programmed amount, direction and mode.
- Returns the result over a valid/ready handshake.
- Sits between the operand/select logic and any consumer of shifted data; it is the sole sequencer of the shift register.

---
 rtl/shifter_pkg.sv | 23 ++
 rtl/shift1_step.sv | 33 +++
 rtl/shift_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared types and constants for the iterative shifter: FSM states, shift
// modes, operand selects and shift directions.
package shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LOG = 2'd0;
  localparam logic [1:0] MODE_ARI = 2'd1;
  localparam logic [1:0] MODE_ROT = 2'd2;

  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_AND  = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift1_step.sv
// Combinational single-bit shift step: value, direction and mode in, the
// shifted value out. Mode 3 falls through to logical behaviour.
module shift1_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_value
);

  logic fill;

  always_comb begin
    fill       = 1'b0;
    next_value = value;
    if (dir == DIR_LEFT) begin
      // Arithmetic left is identical to logical left.
      if (mode == MODE_ROT) fill = value[WIDTH-1];
      next_value = {value[WIDTH-2:0], fill};
    end else begin
      case (mode)
        MODE_ROT: fill = value[0];
        MODE_ARI: fill = value[WIDTH-1];
        default:  fill = 1'b0;
      endcase
      next_value = {fill, value[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative shift sequencer: selects an operand, shifts it one bit per clock
// for the latched amount, then offers the result on a valid/ready output.
module shift_sequencer
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds its data until then, ready never waits on valid.

  state_t           state, state_next;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] stepped;
  logic [AMT_W-1:0] count;
  logic             dir_r;
  logic [1:0]       mode_r;
  logic             accept;

  always_comb begin
    operand = '0;
    case (sel)
      SEL_A:   operand = a;
      SEL_B:   operand = b;
      SEL_AND: operand = a & b;
      default: operand = '0;
    endcase
  end

  shift1_step #(.WIDTH(WIDTH)) u_step (
    .value      (sreg),
    .dir        (dir_r),
    .mode       (mode_r),
    .next_value (stepped)
  );

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = (amt != '0) ? SHIFT : DONE;
      SHIFT: if (count <= AMT_W'(1)) state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) & ~rst;
    out_valid = (state == DONE);
    busy      = (state == SHIFT) | (state == DONE);
  end

  // Request fields are captured once at acceptance; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg   <= '0;
      count  <= '0;
      dir_r  <= DIR_LEFT;
      mode_r <= MODE_LOG;
    end else if (accept) begin
      sreg   <= operand;
      count  <= amt;
      dir_r  <= dir;
      mode_r <= mode;
    end else if (state == SHIFT) begin
      sreg  <= stepped;
      count <= count - AMT_W'(1);
    end
  end

  assign q = sreg;

endmodule
